// File: rtl/wb_arbiter.sv
// wb_arbiter: single writer for the register-file write port.
// Merges single-cycle ALU results with load results. Loads are queued in a
// small circular FIFO, and a starvation counter forces the FIFO head through
// after it has waited STARVE_MAX cycles behind ALU traffic.
// Optional feature macro: WB_X0_FILTER_EN. When it is defined, writes to x0
// are dropped here instead of being passed on to the register file.
module wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [4:0]             alu_rd,
  input  logic [31:0]            alu_data,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [4:0]             ld_rd,
  input  logic [31:0]            ld_data,
  output logic                   wen,
  output logic [4:0]             regW_sel,
  output logic [31:0]            regW_i,
  output logic [$clog2(DEPTH):0] ld_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [SW-1:0] SMAX_C  = SW'(STARVE_MAX);

  // Pointer increment; DEPTH is a power of two, so natural overflow wraps.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return p + PW'(1);
  endfunction

  logic [36:0]   mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] ld_count_r;
  logic [SW-1:0] cnt_r;
  logic          wen_r;
  logic [4:0]    sel_r;
  logic [31:0]   data_r;

  logic          empty_s;
  logic          full_s;
  logic          starve_s;
  logic          alu_wr_s;
  logic          push_s;
  logic          pop_s;
  logic          wr_en_s;
  logic [36:0]   head_s;
  logic [4:0]    wr_rd_s;
  logic [31:0]   wr_data_s;
  logic [CW-1:0] ld_count_nx_s;

  // Arbitration: starvation first, then ALU, then FIFO head, else idle.
  always_comb begin
    empty_s   = (ld_count_r == CW'(0));
    full_s    = (ld_count_r == DEPTH_C);
    starve_s  = (cnt_r == SMAX_C) && !empty_s;
    ld_ready  = !full_s;
    alu_ready = !starve_s;
    head_s    = mem_r[rd_ptr_r];
`ifdef WB_X0_FILTER_EN
    // x0 results are accepted but produce no write and no FIFO entry.
    alu_wr_s  = alu_valid && !starve_s && (alu_rd != 5'd0);
    push_s    = ld_valid && !full_s && (ld_rd != 5'd0);
`else
    alu_wr_s  = alu_valid && !starve_s;
    push_s    = ld_valid && !full_s;
`endif
    // A starving head always pops, because alu_wr_s is forced low then.
    pop_s     = !empty_s && !alu_wr_s;
    wr_en_s   = alu_wr_s || pop_s;
    if (alu_wr_s) begin
      wr_rd_s   = alu_rd;
      wr_data_s = alu_data;
    end else if (pop_s) begin
      wr_rd_s   = head_s[36:32];
      wr_data_s = head_s[31:0];
    end else begin
      wr_rd_s   = sel_r;
      wr_data_s = data_r;
    end
    case ({push_s, pop_s})
      2'b10:   ld_count_nx_s = ld_count_r + CW'(1);
      2'b01:   ld_count_nx_s = ld_count_r - CW'(1);
      default: ld_count_nx_s = ld_count_r;
    endcase
  end

  // FIFO storage; stale entries are harmless because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {ld_rd, ld_data};
    end
  end

  // FIFO pointers, occupancy and starvation counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      ld_count_r <= '0;
      cnt_r      <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      ld_count_r <= ld_count_nx_s;
      if (empty_s || pop_s) begin
        cnt_r <= '0;
      end else if (cnt_r != SMAX_C) begin
        cnt_r <= cnt_r + SW'(1);
      end
    end
  end

  // Registered write port; address/data hold when there is no write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_r  <= 1'b0;
      sel_r  <= 5'd0;
      data_r <= 32'd0;
    end else begin
      wen_r  <= wr_en_s;
      sel_r  <= wr_rd_s;
      data_r <= wr_data_s;
    end
  end

  assign wen      = wen_r;
  assign regW_sel = sel_r;
  assign regW_i   = data_r;
  assign ld_count = ld_count_r;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter (DEPTH=4, STARVE_MAX=3).
// Expected values are hand-computed from the arbitration rules.
module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        wen;
  logic [4:0]  regW_sel;
  logic [31:0] regW_i;
  logic [2:0]  ld_count;

  int checks;
  int failures;

  wb_arbiter #(.DEPTH(4), .STARVE_MAX(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .alu_valid(alu_valid),
    .alu_ready(alu_ready),
    .alu_rd   (alu_rd),
    .alu_data (alu_data),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_rd    (ld_rd),
    .ld_data  (ld_data),
    .wen      (wen),
    .regW_sel (regW_sel),
    .regW_i   (regW_i),
    .ld_count (ld_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic w, input logic [4:0] s, input logic [31:0] d);
    chk({tag, ".wen"}, {31'd0, wen}, {31'd0, w});
    chk({tag, ".sel"}, {27'd0, regW_sel}, {27'd0, s});
    chk({tag, ".data"}, regW_i, d);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    alu_valid = 1'b0;
    alu_rd    = 5'd0;
    alu_data  = 32'd0;
    ld_valid  = 1'b0;
    ld_rd     = 5'd0;
    ld_data   = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk_wr("reset", 1'b0, 5'd0, 32'd0);
    chk("reset.ld_count", {29'd0, ld_count}, 32'd0);
    chk("reset.ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("reset.alu_ready", {31'd0, alu_ready}, 32'd1);

    // ALU path: write one cycle after acceptance, then idle with held address/data
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 1'b0;
    chk_wr("alu.n1", 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    chk_wr("alu.n2", 1'b0, 5'd5, 32'hDEADBEEF);

    // Load order 7,8,9: first write two edges after first push
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h70;
    tick();
    chk("ld.e0.wen", {31'd0, wen}, 32'd0);
    chk("ld.e0.count", {29'd0, ld_count}, 32'd1);
    ld_rd = 5'd8; ld_data = 32'h80;
    tick();
    chk_wr("ld.e1", 1'b1, 5'd7, 32'h70);
    ld_rd = 5'd9; ld_data = 32'h90;
    tick();
    chk_wr("ld.e2", 1'b1, 5'd8, 32'h80);
    ld_valid = 1'b0;
    tick();
    chk_wr("ld.e3", 1'b1, 5'd9, 32'h90);
    chk("ld.e3.count", {29'd0, ld_count}, 32'd0);
    tick();
    chk("ld.e4.wen", {31'd0, wen}, 32'd0);

    // FIFO full with continuous ALU traffic; starvation forces rd1 out
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA0;
    for (int i = 1; i <= 4; i++) begin
      ld_valid = 1'b1; ld_rd = 5'(i); ld_data = 32'h10 + 32'(i);
      chk("full.pre.alu_ready", {31'd0, alu_ready}, 32'd1);
      tick();
      chk_wr("full.alu", 1'b1, 5'd10, 32'hA0);
      chk("full.count", {29'd0, ld_count}, 32'(i));
    end
    // count=4, cnt=3: full and starving
    chk("full.ld_ready", {31'd0, ld_ready}, 32'd0);
    chk("full.alu_ready", {31'd0, alu_ready}, 32'd0);
    ld_rd = 5'd5; ld_data = 32'h15;   // must not be pushed while full
    tick();
    ld_valid = 1'b0;
    chk_wr("full.pop1", 1'b1, 5'd1, 32'h11);
    chk("full.pop1.count", {29'd0, ld_count}, 32'd3);
    chk("full.pop1.ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("full.pop1.alu_ready", {31'd0, alu_ready}, 32'd1);
    tick();
    chk("full.c1.alu_ready", {31'd0, alu_ready}, 32'd1);
    chk_wr("full.c1", 1'b1, 5'd10, 32'hA0);
    tick();
    chk("full.c2.alu_ready", {31'd0, alu_ready}, 32'd1);
    tick();
    chk("full.c3.alu_ready", {31'd0, alu_ready}, 32'd0);
    alu_valid = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk_wr("full.drain", 1'b1, 5'(i), 32'h10 + 32'(i));
      chk("full.drain.count", {29'd0, ld_count}, 32'(4 - i));
    end
    tick();
    chk("full.idle.wen", {31'd0, wen}, 32'd0);

    // Simultaneous push/pop at count 2, pointers wrapping over 10 iterations
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA0;
    ld_valid = 1'b1; ld_rd = 5'd20; ld_data = 32'hC0DE0000 + 32'd20;
    tick();
    ld_rd = 5'd21; ld_data = 32'hC0DE0000 + 32'd21;
    tick();
    chk("pp.count0", {29'd0, ld_count}, 32'd2);
    alu_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ld_rd = 5'(22 + i); ld_data = 32'hC0DE0000 + 32'(22 + i);
      tick();
      chk_wr("pp.iter", 1'b1, 5'(20 + i), 32'hC0DE0000 + 32'(20 + i));
      chk("pp.count", {29'd0, ld_count}, 32'd2);
    end
    ld_valid = 1'b0;
    tick();
    chk_wr("pp.drain30", 1'b1, 5'd30, 32'hC0DE0000 + 32'd30);
    tick();
    chk_wr("pp.drain31", 1'b1, 5'd31, 32'hC0DE0000 + 32'd31);
    chk("pp.count_end", {29'd0, ld_count}, 32'd0);
    tick();

    // Asynchronous reset with 2 loads queued
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hB0;
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h33;
    tick();
    ld_rd = 5'd4; ld_data = 32'h44;
    tick();
    alu_valid = 1'b0; ld_valid = 1'b0;
    chk("rst.pre.count", {29'd0, ld_count}, 32'd2);
    chk("rst.pre.wen", {31'd0, wen}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_wr("rst.async", 1'b0, 5'd0, 32'd0);
    chk("rst.async.count", {29'd0, ld_count}, 32'd0);
    chk("rst.async.ld_ready", {31'd0, ld_ready}, 32'd1);
    #1;
    rst = 1'b0;
    chk("rst.deassert.wen", {31'd0, wen}, 32'd0);
    tick();
    chk("rst.after.wen", {31'd0, wen}, 32'd0);
    chk("rst.after.count", {29'd0, ld_count}, 32'd0);

    // x0 handling
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
    tick();
    alu_valid = 1'b0;
`ifdef WB_X0_FILTER_EN
    chk("x0.alu.wen", {31'd0, wen}, 32'd0);
`else
    chk_wr("x0.alu", 1'b1, 5'd0, 32'h1234);
`endif
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h5678;
    tick();
    ld_valid = 1'b0;
    chk("x0.ld.wen0", {31'd0, wen}, 32'd0);
`ifdef WB_X0_FILTER_EN
    chk("x0.ld.count", {29'd0, ld_count}, 32'd0);
    tick();
    chk("x0.ld.wen1", {31'd0, wen}, 32'd0);
`else
    chk("x0.ld.count", {29'd0, ld_count}, 32'd1);
    tick();
    chk_wr("x0.ld", 1'b1, 5'd0, 32'h5678);
    chk("x0.ld.count_end", {29'd0, ld_count}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
